zigzag_serializer: RTL and testbench

- Downstream neighbour of the quantization stage: consumes one 64-coefficient quantized block (Q16.16, row-major, parallel bus) per transaction.
- Rounds each coefficient to a signed integer and saturates it.
- Streams the coefficients one per beat in JPEG zig-zag order to the entropy-coding stage over a valid/ready handshake.

---
 rtl/zigzag_serializer.sv | 157 +++++++++++++++
 tb/tb_zigzag_serializer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zigzag_serializer.sv
// -----------------------------------------------------------------------------
// zigzag_serializer
//
// Accepts one 8x8 block of signed Q16.16 coefficients (row-major, parallel
// bus), then streams it one coefficient per beat in JPEG zig-zag order. Each
// coefficient is rounded half away from zero to an integer and saturated to a
// signed COEF_W-bit value on the way out.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_block carries a block
//   in_ready   block accepted on a rising edge with in_valid && in_ready
//   in_block   64 x 32-bit Q16.16 words, element i at [32*i +: 32]
//   out_valid  out_coeff / out_index / out_last are valid
//   out_ready  downstream accepts a beat when out_valid && out_ready
//   out_coeff  rounded, saturated coefficient
//   out_index  zig-zag position 0..63 of the current beat
//   out_last   high on the beat with out_index == 63
// -----------------------------------------------------------------------------
module zigzag_serializer #(
    parameter int COEF_W = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2047:0]       in_block,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [COEF_W-1:0]   out_coeff,
    output logic [5:0]          out_index,
    output logic                out_last
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Zig-zag position -> row-major element index.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    localparam logic signed [32:0] SAT_MAX = (33'sd1 <<< (COEF_W - 1)) - 33'sd1;
    localparam logic signed [32:0] SAT_MIN = -(33'sd1 <<< (COEF_W - 1));

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        load;
    logic [31:0] word_flat [64];

    // ---------------------------------------------------------------- control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                cnt_d    = 6'd0;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (cnt_q != 6'd63) begin
                        cnt_d = cnt_q + 6'd1;
                    end else begin
                        // Last beat leaves this cycle: a waiting block can be
                        // taken now so the next stream starts without a bubble.
                        in_ready = 1'b1;
                        cnt_d    = 6'd0;
                        if (in_valid) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------------------------------------------------- block storage
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_word
            logic [31:0] word_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_q <= 32'd0;
                end else if (load) begin
                    word_q <= in_block[32*gi +: 32];
                end
            end

            assign word_flat[gi] = word_q;
        end
    endgenerate

    // ------------------------------------------------- round and saturate
    logic [31:0]        sel_word;
    logic signed [32:0] rnd_sum;
    logic signed [32:0] rnd_shr;
    logic [COEF_W-1:0]  coef_sat;

    assign sel_word = word_flat[ZZ[cnt_q]];

    // 33 bits hold v + 0x8000 for the largest positive v, so no overflow.
    // Adding 0x7FFF on negatives makes the floor shift round -x.5 to -(x+1).
    assign rnd_sum = $signed({sel_word[31], sel_word})
                   + (sel_word[31] ? 33'sh0_7FFF : 33'sh0_8000);
    assign rnd_shr = rnd_sum >>> 16;

    always_comb begin
        coef_sat = rnd_shr[COEF_W-1:0];
        if (rnd_shr > SAT_MAX) begin
            coef_sat = SAT_MAX[COEF_W-1:0];
        end else if (rnd_shr < SAT_MIN) begin
            coef_sat = SAT_MIN[COEF_W-1:0];
        end
    end

    // ---------------------------------------------------------------- outputs
    // Everything is gated by the registered state so an asynchronous reset
    // drives the whole output bundle to zero immediately.
    assign out_valid = (state_q == STREAM);
    assign out_index = out_valid ? cnt_q : 6'd0;
    assign out_last  = out_valid && (cnt_q == 6'd63);
    assign out_coeff = out_valid ? coef_sat : '0;

endmodule

// File: tb/tb_zigzag_serializer.sv
module tb_zigzag_serializer;

    localparam int COEF_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2047:0]     in_block = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [COEF_W-1:0] out_coeff;
    logic [5:0]        out_index;
    logic              out_last;

    zigzag_serializer #(.COEF_W(COEF_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coeff (out_coeff),
        .out_index (out_index),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ------------------------------------------------------------------ model
    // Zig-zag order by walking anti-diagonals, alternating direction.
    function automatic int zz_of(input int pos);
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin
                    if (k == pos) return r * 8 + (s - r);
                    k++;
                end
            end else begin
                for (int r = hi; r >= lo; r--) begin
                    if (k == pos) return r * 8 + (s - r);
                    k++;
                end
            end
        end
        return -1;
    endfunction

    function automatic int round_sat(input logic [31:0] w);
        longint v = longint'($signed(w));
        longint r;
        longint lim = longint'(1) << (COEF_W - 1);
        if (v >= 0) r = (v + 32768) / 65536;
        else        r = -((-v + 32768) / 65536);
        if (r > lim - 1) r = lim - 1;
        if (r < -lim)    r = -lim;
        return int'(r);
    endfunction

    typedef struct {
        int coeff;
        int idx;
        bit last;
    } beat_t;

    beat_t expq[$];
    int    seen_coeff[64];
    int    cur_run = 0;
    int    max_run = 0;
    bit    exp_rdy;

    function automatic void push_block(input logic [2047:0] blk);
        for (int k = 0; k < 64; k++) begin
            beat_t b;
            b.coeff = round_sat(blk[32*zz_of(k) +: 32]);
            b.idx   = k;
            b.last  = (k == 63);
            expq.push_back(b);
        end
    endfunction

    // ---------------------------------------------------------------- compare
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            cur_run = 0;
        end else begin
            exp_rdy = (expq.size() == 0) || (expq.size() == 1 && out_ready);
            check("in_ready", int'(in_ready), int'(exp_rdy));
            check("out_valid", int'(out_valid), int'(expq.size() != 0));
            if (expq.size() != 0) begin
                check("out_coeff", int'($signed(out_coeff)), expq[0].coeff);
                check("out_index", int'(out_index), expq[0].idx);
                check("out_last", int'(out_last), int'(expq[0].last));
                if (out_ready) begin
                    seen_coeff[out_index] = int'($signed(out_coeff));
                    void'(expq.pop_front());
                end
            end
            if (out_valid) cur_run++;
            else cur_run = 0;
            if (cur_run > max_run) max_run = cur_run;
            if (in_valid && exp_rdy) push_block(in_block);
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic send_block(input logic [2047:0] blk);
        bit accepted = 0;
        @(posedge clk); #1;
        in_block = blk;
        in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!accepted) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!out_valid) begin
                idle = 1;
                break;
            end
        end
        check("idle_reached", int'(idle), 1);
        check("idle_in_ready", int'(in_ready), 1);
    endtask

    task automatic wait_index(input int idx);
        bit hit = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (out_valid && out_index == 6'(idx)) begin
                hit = 1;
                break;
            end
        end
        if (!hit) check("wait_index_timeout", 0, 1);
    endtask

    function automatic logic [2047:0] ramp_block();
        logic [2047:0] b;
        for (int i = 0; i < 64; i++) b[32*i +: 32] = 32'(i) << 16;
        return b;
    endfunction

    function automatic logic [2047:0] rand_block();
        logic [2047:0] b;
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w = $urandom;
            if (i % 3 != 0) w = {{8{w[31]}}, w[31:8]};  // mostly in range
            b[32*i +: 32] = w;
        end
        return b;
    endfunction

    logic [2047:0] blk_a, blk_b;
    int            pos_lit [10] = '{0, 1, 2, 3, 4, 5, 20, 35, 61, 63};
    int            ord_lit [10] = '{0, 1, 8, 16, 9, 2, 40, 56, 55, 63};
    int            rm_idx  [10] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};
    logic [31:0]   rs_word [10] = '{32'h00018000, 32'hFFFE8000, 32'h00007FFF,
                                    32'hFFFF8000, 32'h00004000, 32'hFFFF0000,
                                    32'h7FFF0000, 32'h80000000, 32'h07FF0000,
                                    32'hF8000000};
    int            rs_exp  [10] = '{2, -2, 0, -1, 0, -1, 2047, -2048, 2047, -2048};

    initial begin
        // Reset state.
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_index", int'(out_index), 0);
        check("rst_out_coeff", int'(out_coeff), 0);
        check("rst_in_ready", int'(in_ready), 1);

        // Pin the model.
        check("model_zz2", zz_of(2), 8);
        check("model_zz61", zz_of(61), 55);
        check("model_rnd_neg_half", round_sat(32'hFFFF8000), -1);
        check("model_sat_min", round_sat(32'h80000000), -2048);

        @(posedge clk); #1;
        rst_n = 1'b1;

        // Ordering.
        for (int i = 0; i < 64; i++) seen_coeff[i] = -9999;
        send_block(ramp_block());
        wait_idle();
        for (int i = 0; i < 10; i++)
            check($sformatf("order_pos%0d", pos_lit[i]), seen_coeff[pos_lit[i]], ord_lit[i]);

        // Rounding and saturation.
        blk_a = rand_block();
        for (int i = 0; i < 10; i++) blk_a[32*rm_idx[i] +: 32] = rs_word[i];
        send_block(blk_a);
        wait_idle();
        for (int i = 0; i < 10; i++)
            check($sformatf("round_sat_pos%0d", i), seen_coeff[i], rs_exp[i]);

        // Backpressure at beat 10.
        blk_a = rand_block();
        send_block(blk_a);
        wait_index(10);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_index", int'(out_index), 10);
            check("bp_coeff", int'($signed(out_coeff)), round_sat(blk_a[32*zz_of(10) +: 32]));
            check("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        wait_idle();

        // Back-to-back blocks.
        max_run = 0;
        blk_a = rand_block();
        blk_b = rand_block();
        send_block(blk_a);
        send_block(blk_b);
        wait_idle();
        check("b2b_run", max_run, 128);

        // Reset mid-stream.
        send_block(rand_block());
        wait_index(30);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_last", int'(out_last), 0);
        check("mid_rst_out_index", int'(out_index), 0);
        check("mid_rst_out_coeff", int'(out_coeff), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 64; i++) seen_coeff[i] = -9999;
        send_block(ramp_block());
        wait_idle();
        check("post_rst_first", seen_coeff[0], 0);
        check("post_rst_last", seen_coeff[63], 63);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
